yiwei_kongzhi: RTL and testbench

Serial-load controller sitting directly upstream of the team's 4-bit bidirectional shift register. It accepts a parallel word and an operation code over a valid/ready handshake, then drives the shift register's `sel`, `Rin`, `Lin` and `data` inputs cycle by cycle. Depending on the operation, it shifts the word in serially from the right or the left, loads it in parallel, or performs a no-op. It pulses `done` when the downstream register holds the result, so a sequencer can chain commands without counting cycles.

---
 rtl/yiwei_pkg.sv | 18 +
 rtl/yiwei_kongzhi.sv | 114 +++++++++++
 tb/tb_yiwei_kongzhi.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/yiwei_pkg.sv
// Shared encodings for the serial-load controller and its downstream shift register.
package yiwei_pkg;

   // Downstream sel codes. cmd_op uses the same encoding.
   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   // Controller FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      SHIFT = 2'b10,
      FIN   = 2'b11
   } state_t;

endpackage

// File: rtl/yiwei_kongzhi.sv
// Serial-load controller: takes a word and an op over valid/ready and drives a
// bidirectional shift register's sel/Rin/Lin/data so that it ends up holding
// the word. done pulses for one cycle when the register holds the result.
module yiwei_kongzhi
   import yiwei_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   output logic [1:0]       sel,
   output logic             Rin,
   output logic             Lin,
   output logic [WIDTH-1:0] data,
   output logic             busy,
   output logic             done
);

   localparam int unsigned   CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] word, word_nxt;
   logic [1:0]       op, op_nxt;
   logic [1:0]       sel_nxt;
   logic             rin_nxt, lin_nxt, done_nxt;
   logic [WIDTH-1:0] data_nxt;

   // Handshake and status decode straight from the state flops.
   assign cmd_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   // State, counter, latched command and registered downstream drive.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state <= IDLE;
         cnt   <= '0;
         word  <= '0;
         op    <= SEL_HOLD;
         sel   <= SEL_HOLD;
         Rin   <= 1'b0;
         Lin   <= 1'b0;
         data  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         word  <= word_nxt;
         op    <= op_nxt;
         sel   <= sel_nxt;
         Rin   <= rin_nxt;
         Lin   <= lin_nxt;
         data  <= data_nxt;
         done  <= done_nxt;
      end
   end

   // Next state, then outputs decoded from the next state so they line up
   // with the cycle the downstream register acts on them.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      word_nxt  = word;
      op_nxt    = op;
      sel_nxt   = SEL_HOLD;
      rin_nxt   = 1'b0;
      lin_nxt   = 1'b0;
      data_nxt  = '0;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (cmd_valid) begin
               word_nxt = cmd_data;
               op_nxt   = cmd_op;
               cnt_nxt  = '0;
               case (cmd_op)
                  SEL_LOAD:         state_nxt = LOAD;
                  SEL_SHR, SEL_SHL: state_nxt = SHIFT;
                  default:          state_nxt = FIN;
               endcase
            end
         end
         LOAD:  state_nxt = FIN;
         SHIFT: begin
            if (cnt == CNT_LAST) state_nxt = FIN;
            else                 cnt_nxt   = cnt + CW'(1);
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      case (state_nxt)
         LOAD: begin
            sel_nxt  = SEL_LOAD;
            data_nxt = word_nxt;
         end
         SHIFT: begin
            sel_nxt = op_nxt;
            // Right shift enters at the MSB, so feed LSB first; left is mirrored.
            if (op_nxt == SEL_SHR) rin_nxt = word_nxt[cnt_nxt];
            else                   lin_nxt = word_nxt[CNT_LAST - cnt_nxt];
         end
         FIN:     done_nxt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_yiwei_kongzhi.sv
// Bench for yiwei_kongzhi with a behavioural 4-bit bidirectional shift
// register as the downstream sink; expected register contents are queued at
// command issue and compared whenever done pulses.
module tb_yiwei_kongzhi;
   import yiwei_pkg::*;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [1:0]   cmd_op = 2'b00;
   logic [W-1:0] cmd_data = '0;
   logic [1:0]   sel;
   logic         Rin, Lin;
   logic [W-1:0] data;
   logic         busy, done;

   logic [W-1:0] q_ds;
   logic         clr_n;

   int           n_checks = 0;
   int           n_fails  = 0;
   logic [W-1:0] exp_q[$];

   yiwei_kongzhi #(.WIDTH(W)) dut (
      .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .sel(sel), .Rin(Rin), .Lin(Lin),
      .data(data), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Downstream shift register, cleared active-low from ~clr.
   assign clr_n = ~clr;
   always @(posedge clk or negedge clr_n) begin
      if (!clr_n) q_ds <= '0;
      else begin
         case (sel)
            2'b01:   q_ds <= {Rin, q_ds[W-1:1]};
            2'b10:   q_ds <= {q_ds[W-2:0], Lin};
            2'b11:   q_ds <= data;
            default: q_ds <= q_ds;
         endcase
      end
   end

   // Scoreboard: every done pulse must match the oldest queued expectation.
   always begin : mon
      logic [W-1:0] e;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected_done q=%b required no done", q_ds);
            n_fails++;
         end else begin
            e = exp_q.pop_front();
            if (q_ds !== e) begin
               $display("FAIL sb_result q=%b required %b", q_ds, e);
               n_fails++;
            end
         end
      end
   end

   // Drive one command and return #1 after its acceptance edge.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] d, input bit track);
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      if (track) exp_q.push_back((op == 2'b00) ? q_ds : d);
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         $display("FAIL issue_ready ready=%b required 1", cmd_ready);
         n_fails++;
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1 clr = 1'b1;
      #1;
      n_checks++;
      if ({sel, Rin, Lin, data, done, busy, cmd_ready} !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL reset_values sel=%b Rin=%b Lin=%b data=%b done=%b busy=%b ready=%b required 00 0 0 0000 0 0 1",
                  sel, Rin, Lin, data, done, busy, cmd_ready);
         n_fails++;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic test_shr();
      logic [W-1:0] w;
      w = 4'b1011;
      issue(2'b01, w, 1'b1);
      for (int i = 0; i < W; i++) begin
         n_checks++;
         if (sel !== 2'b01 || Rin !== w[i] || Lin !== 1'b0) begin
            $display("FAIL shr_bit%0d sel=%b Rin=%b Lin=%b required 01 %b 0", i, sel, Rin, Lin, w[i]);
            n_fails++;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (done !== 1'b1 || q_ds !== w || sel !== 2'b00) begin
         $display("FAIL shr_done done=%b q=%b sel=%b required 1 %b 00", done, q_ds, sel, w);
         n_fails++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
         $display("FAIL shr_ready ready=%b done=%b required 1 0", cmd_ready, done);
         n_fails++;
      end
   endtask

   task automatic test_shl();
      logic [W-1:0] w;
      w = 4'b1011;
      issue(2'b10, w, 1'b1);
      for (int i = 0; i < W; i++) begin
         n_checks++;
         if (sel !== 2'b10 || Lin !== w[W-1-i] || Rin !== 1'b0) begin
            $display("FAIL shl_bit%0d sel=%b Lin=%b Rin=%b required 10 %b 0", i, sel, Lin, Rin, w[W-1-i]);
            n_fails++;
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (done !== 1'b1 || q_ds !== w) begin
         $display("FAIL shl_done done=%b q=%b required 1 %b", done, q_ds, w);
         n_fails++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load();
      issue(2'b11, 4'b0110, 1'b1);
      n_checks++;
      if (sel !== 2'b11 || data !== 4'b0110 || busy !== 1'b1) begin
         $display("FAIL load_drive sel=%b data=%b busy=%b required 11 0110 1", sel, data, busy);
         n_fails++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || q_ds !== 4'b0110 || data !== 4'b0000 || sel !== 2'b00) begin
         $display("FAIL load_done done=%b q=%b data=%b sel=%b required 1 0110 0000 00", done, q_ds, data, sel);
         n_fails++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         $display("FAIL load_ready ready=%b required 1", cmd_ready);
         n_fails++;
      end
   endtask

   task automatic test_noop();
      issue(2'b00, 4'b1111, 1'b1);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0 || sel !== 2'b00) begin
         $display("FAIL noop_done done=%b busy=%b ready=%b sel=%b required 1 1 0 00", done, busy, cmd_ready, sel);
         n_fails++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
         $display("FAIL noop_ready ready=%b done=%b required 1 0", cmd_ready, done);
         n_fails++;
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_data  = 4'b1100;
      exp_q.push_back(4'b1100);
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      // Second command presented while the first is in progress.
      cmd_op   = 2'b10;
      cmd_data = 4'b0101;
      exp_q.push_back(4'b0101);
      repeat (W) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (done !== 1'b1 || q_ds !== 4'b1100) begin
         $display("FAIL b2b_first done=%b q=%b required 1 1100", done, q_ds);
         n_fails++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         $display("FAIL b2b_idle ready=%b busy=%b required 1 0", cmd_ready, busy);
         n_fails++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (cmd_ready !== 1'b0 || sel !== 2'b10 || Lin !== 1'b0) begin
         $display("FAIL b2b_accept ready=%b sel=%b Lin=%b required 0 10 0", cmd_ready, sel, Lin);
         n_fails++;
      end
      cmd_valid = 1'b0;
      repeat (W) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (done !== 1'b1 || q_ds !== 4'b0101) begin
         $display("FAIL b2b_second done=%b q=%b required 1 0101", done, q_ds);
         n_fails++;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int n;
      issue(2'b01, 4'b1111, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      clr = 1'b1;
      #1;
      n_checks++;
      if ({sel, Rin, Lin, data, done, busy, cmd_ready} !== {2'b00, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL midreset_values sel=%b Rin=%b Lin=%b data=%b done=%b busy=%b ready=%b required 00 0 0 0000 0 0 1",
                  sel, Rin, Lin, data, done, busy, cmd_ready);
         n_fails++;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      repeat (W + 2) begin
         @(posedge clk); #1;
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL midreset_quiet done=%b busy=%b required 0 0", done, busy);
            n_fails++;
         end
      end
      issue(2'b11, 4'b0011, 1'b1);
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      n_checks++;
      if (done !== 1'b1 || q_ds !== 4'b0011) begin
         $display("FAIL midreset_fresh done=%b q=%b required 1 0011", done, q_ds);
         n_fails++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_shr();
      test_shl();
      test_load();
      test_noop();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         $display("FAIL sb_leftover pending=%0d required 0", exp_q.size());
         n_fails++;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time=%0t required finish earlier", $time);
      $fatal(1, "watchdog");
   end

endmodule
